// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  // Fetch FSM states; StHalt is only reachable when misalignment checking is built in.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  // Byte increment between sequential instructions.
  localparam int unsigned PcIncr = 4;

  // Default first fetch address after boot.
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Two-entry packet FIFO between fetch and decode.
// Flush empties the FIFO but leaves the read pointer in place, so the head slot (and the
// packet outputs driven from it) keeps its last value until a new packet is written.
module ifu_fetch_fifo #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_count
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  // Pointer and occupancy update; flush overrides push and pop.
  always_comb begin
    pop_ok   = i_pop && (count_q != 2'd0);
    push_ok  = i_push && !i_flush && (count_q != 2'd2);
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    if (i_flush) begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = rd_ptr_q;
      count_d  = 2'd0;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem read port and hands
// {pc, instr} packets to decode through a two-entry FIFO.
// Optional build macro IFU_MISALIGN_CHK_EN: a redirect to a non word-aligned target halts
// fetch and raises a sticky o_misalign_exc; otherwise low PC bits are ignored.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH   = 2048,
  parameter int unsigned           MEM_DEPTH_W = 11,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = PC_WIDTH'(ResetPcDefault)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_boot_done,
  input  logic                   i_redirect,
  input  logic [PC_WIDTH-1:0]    i_redirect_pc,
  output logic                   o_imem_ren,
  output logic [MEM_DEPTH_W-1:0] o_imem_addr,
  input  logic [INSTR_WIDTH-1:0] i_imem_instr,
  output logic                   o_if_valid,
  input  logic                   i_id_ready,
  output logic [PC_WIDTH-1:0]    o_if_pc,
  output logic [INSTR_WIDTH-1:0] o_if_instr,
  output logic                   o_misalign_exc
);

  // Word-address width derived from the memory depth; equals MEM_DEPTH_W when configured sanely.
  localparam int unsigned AddrW = $clog2(MEM_DEPTH);
  localparam int unsigned PktW  = PC_WIDTH + INSTR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                  inflight_epoch_q, inflight_epoch_d;
  logic                  epoch_q, epoch_d;

  logic                  pop, push, issue, redirect_run;
  logic [2:0]            occupancy;
  logic [1:0]            fifo_count;
  logic [PktW-1:0]       fifo_head;

`ifdef IFU_MISALIGN_CHK_EN
  logic                  misalign_q, misalign_d;
`endif

  // Handshake, issue and capture decisions for the current cycle.
  always_comb begin
    pop          = o_if_valid && i_id_ready;
    redirect_run = i_redirect && (state_q == StRun);
    // Slots already committed (buffered plus in flight) once this cycle's pop retires.
    occupancy    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue        = (state_q == StRun) && !i_redirect && (occupancy < 3'd2);
    // A reply belongs to the current epoch only if no redirect has happened since its issue.
    push         = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_run;
  end

  // Next-state for FSM, PC and in-flight tracking.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q ^ redirect_run;
    inflight_d       = issue;
    inflight_pc_d    = issue ? fetch_pc_q : inflight_pc_q;
    inflight_epoch_d = epoch_q;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_d       = misalign_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_boot_done) state_d = StRun;
      end
      StRun: begin
`ifdef IFU_MISALIGN_CHK_EN
        if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
          state_d    = StHalt;
          misalign_d = 1'b1;
        end
`endif
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase

    if (i_redirect && (state_q != StHalt)) begin
      fetch_pc_d = i_redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(PcIncr);
    end
  end

  // All fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_q       <= misalign_d;
`endif
    end
  end

  ifu_fetch_fifo #(
    .DW (PktW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_run),
    .i_push  (push),
    .i_data  ({inflight_pc_q, i_imem_instr}),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_count (fifo_count)
  );

  assign o_imem_ren  = issue;
  assign o_imem_addr = fetch_pc_q[AddrW+1:2];
  assign o_if_valid  = (fifo_count != 2'd0);
  assign o_if_pc     = fifo_head[INSTR_WIDTH +: PC_WIDTH];
  assign o_if_instr  = fifo_head[INSTR_WIDTH-1:0];

`ifdef IFU_MISALIGN_CHK_EN
  assign o_misalign_exc = misalign_q;
`else
  assign o_misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot hold, streaming, backpressure, redirects, optional
// misalignment halt (IFU_MISALIGN_CHK_EN) and mid-run reset. Imem word k holds value k.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ren;
  logic [10:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_exc;

  int checks = 0;
  int errors = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .i_boot_done    (boot_done),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_imem_ren     (imem_ren),
    .o_imem_addr    (imem_addr),
    .i_imem_instr   (imem_instr),
    .o_if_valid     (if_valid),
    .i_id_ready     (id_ready),
    .o_if_pc        (if_pc),
    .o_if_instr     (if_instr),
    .o_misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  // Synchronous imem model: word at address k reads as k.
  always @(posedge clk) begin
    if (imem_ren) imem_instr <= 32'(imem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, " valid"}, 64'(if_valid), 64'd1);
    chk({tag, " pc"}, 64'(if_pc), 64'(pc));
    chk({tag, " instr"}, 64'(if_instr), 64'(ins));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    boot_done   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    tick();
    tick();
    chk("reset ren", 64'(imem_ren), 64'd0);
    chk("reset valid", 64'(if_valid), 64'd0);
    chk("reset pc", 64'(if_pc), 64'd0);
    chk("reset instr", 64'(if_instr), 64'd0);
    chk("reset misalign", 64'(misalign_exc), 64'd0);
    rst = 1'b0;

    // Boot hold: no fetch while boot is incomplete.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("boot hold ren", 64'(imem_ren), 64'd0);
    end

    boot_done = 1'b1;
    id_ready  = 1'b1;
    settle();
    chk("boot idle ren", 64'(imem_ren), 64'd0);
    tick();
    chk("boot ren", 64'(imem_ren), 64'd1);
    chk("boot addr", 64'(imem_addr), 64'd0);
    chk("boot valid early", 64'(if_valid), 64'd0);
    tick();
    chk("boot ren2", 64'(imem_ren), 64'd1);
    chk("boot addr2", 64'(imem_addr), 64'd1);
    chk("boot valid early2", 64'(if_valid), 64'd0);
    tick();
    chk_pkt("stream k0", 32'h0, 32'h0);

    // Streaming: one packet per cycle, no bubbles.
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_pkt("stream", 32'(4 * k), 32'(k));
    end

    // Backpressure: FIFO fills, ren held low, head stays put.
    id_ready = 1'b0;
    settle();
    chk("bp ren now", 64'(imem_ren), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_pkt("bp hold", 32'd28, 32'd7);
      chk("bp ren", 64'(imem_ren), 64'd0);
    end
    id_ready = 1'b1;
    settle();
    chk("bp resume ren", 64'(imem_ren), 64'd1);
    chk("bp resume addr", 64'(imem_addr), 64'd9);
    for (int k = 8; k < 11; k++) begin
      tick();
      chk_pkt("bp resume", 32'(4 * k), 32'(k));
    end

    // Redirect with a word in flight, decode accepting pc 40 in the same cycle.
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    settle();
    chk("redir ren", 64'(imem_ren), 64'd0);
    tick();
    redirect = 1'b0;
    settle();
    chk("redir valid0", 64'(if_valid), 64'd0);
    chk("redir ren1", 64'(imem_ren), 64'd1);
    chk("redir addr", 64'(imem_addr), 64'h40);
    tick();
    chk("redir valid1", 64'(if_valid), 64'd0);
    tick();
    chk_pkt("redir target", 32'h100, 32'h40);
    tick();
    chk_pkt("redir next", 32'h104, 32'h41);

    // Fill FIFO, then redirect while full with a pop: 0x104 taken, 0x108 dropped.
    id_ready = 1'b0;
    settle();
    tick();
    chk_pkt("full head", 32'h104, 32'h41);
    chk("full ren", 64'(imem_ren), 64'd0);
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    settle();
    chk("full redir ren", 64'(imem_ren), 64'd0);
    tick();
    redirect = 1'b0;
    settle();
    chk("full redir valid", 64'(if_valid), 64'd0);
    chk("full redir ren1", 64'(imem_ren), 64'd1);
    chk("full redir addr", 64'(imem_addr), 64'h80);
    tick();
    tick();
    chk_pkt("full redir target", 32'h200, 32'h80);

    // Redirect to a non word-aligned target.
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    settle();
    tick();
    redirect = 1'b0;
    settle();
`ifdef IFU_MISALIGN_CHK_EN
    chk("misalign exc", 64'(misalign_exc), 64'd1);
    chk("misalign ren", 64'(imem_ren), 64'd0);
    chk("misalign valid", 64'(if_valid), 64'd0);
    chk("misalign pc hold", 64'(if_pc), 64'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt ren", 64'(imem_ren), 64'd0);
      chk("halt exc", 64'(misalign_exc), 64'd1);
    end
`else
    chk("unaligned exc", 64'(misalign_exc), 64'd0);
    chk("unaligned ren", 64'(imem_ren), 64'd1);
    chk("unaligned addr", 64'(imem_addr), 64'h40);
    tick();
    tick();
    chk_pkt("unaligned target", 32'h102, 32'h40);
    tick();
    chk_pkt("unaligned next", 32'h106, 32'h41);
`endif

    // Asynchronous reset mid-run clears every output immediately.
    rst = 1'b1;
    settle();
    chk("midrst ren", 64'(imem_ren), 64'd0);
    chk("midrst valid", 64'(if_valid), 64'd0);
    chk("midrst pc", 64'(if_pc), 64'd0);
    chk("midrst instr", 64'(if_instr), 64'd0);
    chk("midrst misalign", 64'(misalign_exc), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("reboot idle ren", 64'(imem_ren), 64'd0);
    tick();
    chk("reboot ren", 64'(imem_ren), 64'd1);
    chk("reboot addr", 64'(imem_addr), 64'd0);
    tick();
    tick();
    chk_pkt("reboot pkt", 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
